// File: rtl/uart_cmd_parser_if.sv
`timescale 1ns/1ps
// uart_cmd_parser_if: byte input from the UART receive path plus the
// register-write and error-reporting outputs of the command parser.
interface uart_cmd_parser_if;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_done;
   logic        reg_wr_en;
   logic [7:0]  reg_wr_addr;
   logic [15:0] reg_wr_data;
   logic        frame_err;
   logic [1:0]  err_code;
   logic [7:0]  err_cnt;
   logic        busy;

   // Producer of received bytes and consumer of write/error results
   modport master (
      output uart_rx_data,
      output uart_rx_done,
      input  reg_wr_en,
      input  reg_wr_addr,
      input  reg_wr_data,
      input  frame_err,
      input  err_code,
      input  err_cnt,
      input  busy
   );

   // The parser itself
   modport slave (
      input  uart_rx_data,
      input  uart_rx_done,
      output reg_wr_en,
      output reg_wr_addr,
      output reg_wr_data,
      output frame_err,
      output err_code,
      output err_cnt,
      output busy
   );
endinterface

// File: rtl/uart_cmd_parser.sv
`timescale 1ns/1ps
// uart_cmd_parser: assembles 5-byte frames {HEADER, ADDR, D_H, D_L, CHK}
// from received bytes, checks the 8-bit wrap-around checksum, issues a
// single-cycle register write on success and reports checksum/timeout errors.
module uart_cmd_parser #(
   parameter logic [31:0] CLK_FREQ   = 32'd50_000_000,
   parameter logic [31:0] TIMEOUT_US = 32'd1000,
   parameter logic [7:0]  HEADER     = 8'hA5
) (
   input logic              uart_rx_clk,
   input logic              reset_n,
   uart_cmd_parser_if.slave bus
);

   localparam logic [31:0] TIMEOUT_CNT  = (CLK_FREQ / 32'd1_000_000) * TIMEOUT_US;
   localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CNT - 32'd1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_DH   = 3'd2;
   localparam logic [2:0] S_DL   = 3'd3;
   localparam logic [2:0] S_CHK  = 3'd4;

   logic [2:0]  state;
   logic [2:0]  next_state;
   logic        done_d;
   logic        byte_stb;
   logic [31:0] timeout_cnt;
   logic        timeout_hit;
   logic [7:0]  addr_q;
   logic [7:0]  dh_q;
   logic [7:0]  dl_q;
   logic [7:0]  chk_sum;
   logic        chk_ok;
   logic        chk_bad;

   // A byte arriving on the same cycle as the timeout wins, so the timeout
   // condition is qualified with the absence of a strobe.
   assign byte_stb    = bus.uart_rx_done & ~done_d;
   assign chk_sum     = addr_q + dh_q + dl_q;
   assign timeout_hit = (state != S_IDLE) && (timeout_cnt == TIMEOUT_LAST) && !byte_stb;
   assign chk_ok      = byte_stb && (state == S_CHK) && (bus.uart_rx_data == chk_sum);
   assign chk_bad     = byte_stb && (state == S_CHK) && (bus.uart_rx_data != chk_sum);

   // Delayed copy of uart_rx_done so a long-held flag yields one byte only
   always_ff @(posedge uart_rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         done_d <= 1'b0;
      end else begin
         done_d <= bus.uart_rx_done;
      end
   end

   // Frame sequencing; a HEADER value inside a frame is plain data
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (byte_stb && (bus.uart_rx_data == HEADER)) next_state = S_ADDR;
         S_ADDR:  if (byte_stb) next_state = S_DH;
         S_DH:    if (byte_stb) next_state = S_DL;
         S_DL:    if (byte_stb) next_state = S_CHK;
         S_CHK:   if (byte_stb) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (timeout_hit) begin
         next_state = S_IDLE;
      end
   end

   // State register; busy is registered from the next state so it has no
   // combinational path from the inputs
   always_ff @(posedge uart_rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         bus.busy <= 1'b0;
      end else begin
         state    <= next_state;
         bus.busy <= (next_state != S_IDLE);
      end
   end

   // Inter-byte gap counter, parked at zero while idle
   always_ff @(posedge uart_rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout_cnt <= 32'd0;
      end else if ((state == S_IDLE) || byte_stb || timeout_hit) begin
         timeout_cnt <= 32'd0;
      end else begin
         timeout_cnt <= timeout_cnt + 32'd1;
      end
   end

   // Capture of the frame payload fields
   always_ff @(posedge uart_rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= 8'd0;
         dh_q   <= 8'd0;
         dl_q   <= 8'd0;
      end else if (byte_stb) begin
         case (state)
            S_ADDR:  addr_q <= bus.uart_rx_data;
            S_DH:    dh_q   <= bus.uart_rx_data;
            S_DL:    dl_q   <= bus.uart_rx_data;
            default: ;
         endcase
      end
   end

   // Write strobe and error reporting; write and error never coincide
   // because a checksum result needs a strobe and a timeout needs its absence
   always_ff @(posedge uart_rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.reg_wr_en   <= 1'b0;
         bus.reg_wr_addr <= 8'd0;
         bus.reg_wr_data <= 16'd0;
         bus.frame_err   <= 1'b0;
         bus.err_code    <= 2'b00;
         bus.err_cnt     <= 8'd0;
      end else begin
         bus.reg_wr_en <= chk_ok;
         bus.frame_err <= chk_bad || timeout_hit;
         if (chk_ok) begin
            bus.reg_wr_addr <= addr_q;
            bus.reg_wr_data <= {dh_q, dl_q};
         end
         if (chk_bad) begin
            bus.err_code <= 2'b01;
         end else if (timeout_hit) begin
            bus.err_code <= 2'b10;
         end
         if ((chk_bad || timeout_hit) && (bus.err_cnt != 8'hFF)) begin
            bus.err_cnt <= bus.err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
`timescale 1ns/1ps
// tb_uart_cmd_parser: table-driven frames plus hand-written timeout, reset
// and saturation sequences; expected write/error events are queued when a
// frame is driven and compared when the parser pulses reg_wr_en/frame_err.
module tb_uart_cmd_parser;

   typedef struct {
      logic [4:0][7:0] bytes;
      int              n;
      int              kind;
      logic [7:0]      addr;
      logic [15:0]     data;
   } vec_t;

   typedef struct {
      logic        wr;
      logic        err;
      logic [7:0]  addr;
      logic [15:0] data;
      logic [1:0]  code;
      logic [7:0]  cnt;
   } exp_t;

   logic uart_rx_clk = 1'b0;
   logic reset_n     = 1'b0;

   uart_cmd_parser_if bus();

   uart_cmd_parser #(
      .CLK_FREQ   (32'd50_000_000),
      .TIMEOUT_US (32'd10),
      .HEADER     (8'hA5)
   ) dut (
      .uart_rx_clk (uart_rx_clk),
      .reset_n     (reset_n),
      .bus         (bus)
   );

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int stb_cyc = 0;
   int evt_cyc = 0;

   exp_t exp_q[$];
   vec_t vecs[8];

   logic [7:0]  mdl_addr = 8'd0;
   logic [15:0] mdl_data = 16'd0;
   logic [1:0]  mdl_code = 2'b00;
   logic [7:0]  mdl_cnt  = 8'd0;

   // Free-running clock
   always #5 uart_rx_clk = ~uart_rx_clk;

   // Cycle counter used for latency measurements
   always @(posedge uart_rx_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic push_write(input logic [7:0] addr, input logic [15:0] data);
      exp_t e;
      mdl_addr = addr;
      mdl_data = data;
      e = '{1'b1, 1'b0, addr, data, mdl_code, mdl_cnt};
      exp_q.push_back(e);
   endtask

   task automatic push_err(input logic [1:0] code);
      exp_t e;
      mdl_code = code;
      if (mdl_cnt != 8'hFF) mdl_cnt = mdl_cnt + 8'd1;
      e = '{1'b0, 1'b1, mdl_addr, mdl_data, code, mdl_cnt};
      exp_q.push_back(e);
   endtask

   // Byte strobe edge is the first rising clock after uart_rx_done goes high;
   // consecutive strobes are hold+gap cycles apart.
   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      @(negedge uart_rx_clk);
      bus.uart_rx_data = b;
      bus.uart_rx_done = 1'b1;
      @(posedge uart_rx_clk);
      #1 stb_cyc = cyc;
      repeat (hold - 1) @(posedge uart_rx_clk);
      @(negedge uart_rx_clk);
      bus.uart_rx_done = 1'b0;
      repeat (gap) @(posedge uart_rx_clk);
   endtask

   task automatic applyStimulus(input logic [4:0][7:0] bytes, input int n, input int hold, input int gap);
      for (int k = 0; k < n; k++) send_byte(bytes[4 - k], hold, gap);
   endtask

   task automatic wait_drain(input int max_cyc);
      int waited = 0;
      while (exp_q.size() != 0 && waited < max_cyc) begin
         @(posedge uart_rx_clk);
         waited++;
      end
      @(negedge uart_rx_clk);
      checkOutput("pending_events", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_held(input string tag);
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
      checkOutput({tag, "_addr"}, 32'(bus.reg_wr_addr), 32'(mdl_addr));
      checkOutput({tag, "_data"}, 32'(bus.reg_wr_data), 32'(mdl_data));
      checkOutput({tag, "_code"}, 32'(bus.err_code), 32'(mdl_code));
      checkOutput({tag, "_cnt"}, 32'(bus.err_cnt), 32'(mdl_cnt));
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_wr_en"}, 32'(bus.reg_wr_en), 32'd0);
      checkOutput({tag, "_addr"}, 32'(bus.reg_wr_addr), 32'd0);
      checkOutput({tag, "_data"}, 32'(bus.reg_wr_data), 32'd0);
      checkOutput({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
      checkOutput({tag, "_code"}, 32'(bus.err_code), 32'd0);
      checkOutput({tag, "_cnt"}, 32'(bus.err_cnt), 32'd0);
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   // Scoreboard: every write or error pulse must match the oldest queued event
   always @(negedge uart_rx_clk) begin
      exp_t e;
      if (reset_n && (bus.reg_wr_en || bus.frame_err)) begin
         evt_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event actual wr_en=%0d frame_err=%0d required no pulse",
                     bus.reg_wr_en, bus.frame_err);
         end else begin
            e = exp_q.pop_front();
            checkOutput("evt_wr_en", 32'(bus.reg_wr_en), 32'(e.wr));
            checkOutput("evt_frame_err", 32'(bus.frame_err), 32'(e.err));
            checkOutput("evt_addr", 32'(bus.reg_wr_addr), 32'(e.addr));
            checkOutput("evt_data", 32'(bus.reg_wr_data), 32'(e.data));
            checkOutput("evt_code", 32'(bus.err_code), 32'(e.code));
            checkOutput("evt_cnt", 32'(bus.err_cnt), 32'(e.cnt));
         end
      end
   end

   // Absolute simulation bound
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   // Main test sequence
   initial begin
      // kind: 0 = no event, 1 = write, 2 = checksum error
      vecs[0] = '{{8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C}, 5, 1, 8'h12, 16'h3456};
      vecs[1] = '{{8'hA5, 8'h12, 8'h34, 8'h56, 8'h9D}, 5, 2, 8'h00, 16'h0000};
      vecs[2] = '{{8'hA5, 8'hFF, 8'hFF, 8'h03, 8'h01}, 5, 1, 8'hFF, 16'hFF03};
      vecs[3] = '{{8'h00, 8'h5A, 8'hFF, 8'h00, 8'h00}, 3, 0, 8'h00, 16'h0000};
      vecs[4] = '{{8'hA5, 8'h01, 8'h00, 8'h02, 8'h03}, 5, 1, 8'h01, 16'h0002};
      vecs[5] = '{{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hEF}, 5, 1, 8'hA5, 16'hA5A5};
      vecs[6] = '{{8'hA5, 8'h80, 8'h80, 8'h00, 8'h01}, 5, 2, 8'h00, 16'h0000};
      vecs[7] = '{{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 1, 8'h00, 16'h0000};

      bus.uart_rx_data = 8'h00;
      bus.uart_rx_done = 1'b0;
      repeat (3) @(negedge uart_rx_clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      repeat (5) @(negedge uart_rx_clk);

      $display("[TB] table-driven frames");
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].kind == 1) push_write(vecs[i].addr, vecs[i].data);
         else if (vecs[i].kind == 2) push_err(2'b01);
         applyStimulus(vecs[i].bytes, vecs[i].n, 20, 100);
         wait_drain(50);
         if (vecs[i].kind != 0) checkOutput("chk_latency", 32'(evt_cyc - stb_cyc), 32'd0);
         check_held("vec_after");
      end

      $display("[TB] inter-byte timeout");
      push_err(2'b10);
      send_byte(8'hA5, 20, 100);
      @(negedge uart_rx_clk);
      checkOutput("busy_mid_frame", 32'(bus.busy), 32'd1);
      send_byte(8'h10, 20, 100);
      wait_drain(600);
      checkOutput("timeout_delay", 32'(evt_cyc - stb_cyc), 32'd500);
      check_held("timeout_after");
      push_write(8'h12, 16'h3456);
      applyStimulus({8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C}, 5, 20, 100);
      wait_drain(50);
      check_held("post_timeout_frame");

      $display("[TB] byte on the last cycle of the gap");
      push_write(8'h21, 16'h4365);
      applyStimulus({8'hA5, 8'h21, 8'h43, 8'h65, 8'hC9}, 5, 20, 480);
      wait_drain(50);
      checkOutput("edge_gap_latency", 32'(evt_cyc - stb_cyc), 32'd0);
      check_held("edge_gap_after");

      $display("[TB] stuck-high uart_rx_done");
      push_err(2'b10);
      send_byte(8'hA5, 1000, 10);
      wait_drain(20);
      checkOutput("stuck_timeout_delay", 32'(evt_cyc - stb_cyc), 32'd500);
      check_held("stuck_after");
      push_write(8'h33, 16'h0102);
      applyStimulus({8'hA5, 8'h33, 8'h01, 8'h02, 8'h36}, 5, 20, 100);
      wait_drain(50);
      check_held("post_stuck_frame");

      $display("[TB] reset mid-frame");
      applyStimulus({8'hA5, 8'h12, 8'h34, 8'h00, 8'h00}, 3, 20, 100);
      @(negedge uart_rx_clk);
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      mdl_addr = 8'd0;
      mdl_data = 16'd0;
      mdl_code = 2'b00;
      mdl_cnt  = 8'd0;
      repeat (3) @(negedge uart_rx_clk);
      reset_n = 1'b1;
      push_write(8'h01, 16'h0002);
      applyStimulus({8'hA5, 8'h01, 8'h00, 8'h02, 8'h03}, 5, 20, 100);
      wait_drain(50);
      check_held("post_reset_frame");

      $display("[TB] error counter saturation");
      for (int f = 0; f < 300; f++) begin
         push_err(2'b01);
         applyStimulus({8'hA5, 8'h01, 8'h02, 8'h03, 8'h00}, 5, 2, 2);
      end
      wait_drain(20);
      checkOutput("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);
      check_held("saturation_after");

      repeat (10) @(negedge uart_rx_clk);
      checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
